// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RV32I pipeline: operand forwarding, load-use
// stalls, branch flushes and a data-cache miss sequencer that freezes the pipeline.
module hazard_unit #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic                 MemAccessM,
  input  logic                 CacheHitM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 RefillReq,
  output logic [CNT_WIDTH-1:0] MissCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    FILL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic                 miss_detect;
  logic                 mem_stall;
  logic                 lw_stall;

  // The M stage holds the youngest result, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign lw_stall    = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
  assign miss_detect = (state_q == IDLE) && MemAccessM && !CacheHitM;
  assign mem_stall   = miss_detect || (state_q != IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    miss_cnt_d = miss_cnt_q;
    RefillReq  = 1'b0;
    unique case (state_q)
      IDLE: if (miss_detect) state_d = MISS;
      MISS: begin
        RefillReq = 1'b1;
        if (MemReadyM) state_d = FILL;
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (miss_detect && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // A cache freeze overrides both the branch flush and the load-use bubble; the
  // branch waits in E and flushes on the release cycle.
  always_comb begin
    StallF = lw_stall || mem_stall;
    StallD = lw_stall || mem_stall;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushW = mem_stall;
    FlushE = (lw_stall || PCSrcE) && !mem_stall;
    FlushD = PCSrcE && !mem_stall;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand-written miss/reset/
// saturation sequences and a randomized run against a flag-based reference model.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemAccessM, CacheHitM, MemReadyM;

  logic [1:0]  fa1, fb1, fa2, fb2;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, rr1;
  logic        sf2, sd2, se2, sm2, fd2, fe2, fw2, rr2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  logic [11:0] o1, o2;

  int checks = 0;
  int errors = 0;

  // Reference model state: a refill in progress, a fill cycle pending, misses seen.
  bit m_busy, m_filling;
  int m_cnt;

  hazard_unit dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .CacheHitM(CacheHitM), .MemReadyM(MemReadyM), .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1), .FlushD(fd1),
    .FlushE(fe1), .FlushW(fw1), .RefillReq(rr1), .MissCount(cnt1)
  );

  hazard_unit #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .CacheHitM(CacheHitM), .MemReadyM(MemReadyM), .ForwardAE(fa2), .ForwardBE(fb2),
    .StallF(sf2), .StallD(sd2), .StallE(se2), .StallM(sm2), .FlushD(fd2),
    .FlushE(fe2), .FlushW(fw2), .RefillReq(rr2), .MissCount(cnt2)
  );

  assign o1 = {fa1, fb1, sf1, sd1, se1, sm1, fd1, fe1, fw1, rr1};
  assign o2 = {fa2, fb2, sf2, sd2, se2, sm2, fd2, fe2, fw2, rr2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rwm, rww, rsrc, pc;
    int fa, fb, st, fe, fd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model_vec();
    logic lw, ms;
    lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    ms = m_busy || m_filling || (MemAccessM && !CacheHitM);
    return {ref_fwd(Rs1E), ref_fwd(Rs2E), lw | ms, lw | ms, ms, ms,
            PCSrcE & !ms, (lw | PCSrcE) & !ms, ms, m_busy};
  endfunction

  task automatic model_step();
    if (m_filling) m_filling = 1'b0;
    else if (m_busy) begin
      if (MemReadyM) begin
        m_busy    = 1'b0;
        m_filling = 1'b1;
      end
    end else if (MemAccessM && !CacheHitM) begin
      m_busy = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_filling = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic zero_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MemAccessM, CacheHitM, MemReadyM} = '0;
    ResultSrcE = 2'b00;
  endtask

  initial begin
    int stall_n, refill_n, early_flush;
    zero_inputs();
    model_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs", 32'(o1), 32'h0);
    check("reset_count", 32'(cnt1), 32'h0);
    check("reset_count_sat", 32'(cnt2), 32'h0);
    #1 rst = 1'b0;

    //            rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc  fa fb st fe fd
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0,   2, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0,   1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 9, 0, 3, 9, 1, 1, 0, 0,   0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 9, 0, 9, 9, 1, 1, 0, 0,   0, 2, 0, 0, 0};
    vecs[6]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0};
    vecs[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2, 0,   0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1};
    vecs[10] = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1,   0, 0, 1, 1, 1};
    vecs[11] = '{4, 0, 4, 4, 4, 4, 4, 0, 1, 1, 0,   1, 1, 1, 1, 0};

    foreach (vecs[i]) begin
      logic [11:0] exp;
      Rs1D = 5'(vecs[i].rs1d); Rs2D = 5'(vecs[i].rs2d);
      Rs1E = 5'(vecs[i].rs1e); Rs2E = 5'(vecs[i].rs2e);
      RdE  = 5'(vecs[i].rde);  RdM  = 5'(vecs[i].rdm);  RdW = 5'(vecs[i].rdw);
      RegWriteM  = 1'(vecs[i].rwm);
      RegWriteW  = 1'(vecs[i].rww);
      ResultSrcE = 2'(vecs[i].rsrc);
      PCSrcE     = 1'(vecs[i].pc);
      exp = {2'(vecs[i].fa), 2'(vecs[i].fb), 1'(vecs[i].st), 1'(vecs[i].st),
             2'b00, 1'(vecs[i].fd), 1'(vecs[i].fe), 2'b00};
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(o1), 32'(exp));
      tick();
    end

    // Miss with the refill delivered 4 cycles after MISS entry, branch waiting in E.
    zero_inputs();
    PCSrcE     = 1'b1;
    MemAccessM = 1'b1;
    stall_n = 0; refill_n = 0; early_flush = 0;
    for (int i = 0; i < 8; i++) begin
      CacheHitM = (i == 7);
      MemReadyM = (i == 5);
      @(negedge clk);
      stall_n  += int'(sf1);
      refill_n += int'(rr1);
      if (i == 0) check("miss_count_before", 32'(cnt1), 32'd0);
      if (i < 7) early_flush += int'(fd1) + int'(fe1);
      if (i == 7) begin
        check("miss_release_stall", 32'({sf1, se1, sm1, fw1}), 32'h0);
        check("miss_release_flush", 32'({fd1, fe1}), 32'h3);
        check("miss_count_after", 32'(cnt1), 32'd1);
      end
      tick();
    end
    check("miss_stall_cycles", 32'(stall_n), 32'd7);
    check("miss_refill_cycles", 32'(refill_n), 32'd5);
    check("miss_flush_while_frozen", 32'(early_flush), 32'd0);

    // Asynchronous reset while a refill is outstanding.
    zero_inputs();
    MemAccessM = 1'b1;
    @(negedge clk);
    tick();
    MemAccessM = 1'b0;
    #2;
    check("pre_reset_refill", 32'(rr1), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset_refill", 32'(rr1), 32'd0);
    check("async_reset_stall", 32'(se1), 32'd0);
    check("async_reset_count", 32'(cnt1), 32'd0);
    rst = 1'b0;
    MemReadyM = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(o1), 32'h0);
    tick();
    @(negedge clk);
    check("post_reset_ready_ignored", 32'({rr1, sm1}), 32'h0);
    tick();

    // Back-to-back minimum-latency misses, saturating the 2-bit counter.
    zero_inputs();
    MemAccessM = 1'b1;
    stall_n = 0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        MemReadyM = (c == 1);
        @(negedge clk);
        stall_n += int'(se1);
        if (c == 1) begin
          check($sformatf("sat_count_%0d", k), 32'(cnt2), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
          check($sformatf("wide_count_%0d", k), 32'(cnt1), 32'(k + 1));
        end
        tick();
      end
    end
    check("min_latency_stalls", 32'(stall_n), 32'd15);
    MemAccessM = 1'b0;
    MemReadyM  = 1'b0;
    @(negedge clk);
    check("after_misses_idle", 32'(o1), 32'h0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemAccessM = ($urandom_range(0, 2) == 0);
      CacheHitM  = 1'($urandom_range(0, 1));
      MemReadyM  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      check("rand_outputs", 32'(o1), 32'(model_vec()));
      check("rand_outputs_sat", 32'(o2), 32'(model_vec()));
      check("rand_count", 32'(cnt1), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("rand_count_sat", 32'(cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
